// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier among NUM_REQ
// requesters; returns tagged results and keeps saturating exception/overflow counts.
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_result,
  input  logic                  mul_exception,
  input  logic                  mul_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_exception,
  output logic                  rsp_overflow,
  output logic                  busy,
  input  logic                  clr_stats,
  output logic [CNT_W-1:0]      exc_count,
  output logic [CNT_W-1:0]      ovf_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       op_a_q, op_b_q, res_q;
  logic              exc_q, ovf_q;
  logic [CNT_W-1:0]  exc_cnt_q, ovf_cnt_q;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       sel_a, sel_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-pass search: indices at or above ptr first, then the wrapped-around ones.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && ID_W'(i) >= ptr_q) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && ID_W'(i) < ptr_q) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && gnt_found && (gnt_idx == ID_W'(i));
    end
  end

  assign ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            id_q    <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= mul_result;
          exc_q   <= mul_exception;
          ovf_q   <= mul_overflow;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Clear wins over a same-edge capture increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (clr_stats) begin
      exc_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (state_q == EXEC) begin
      if (mul_exception) exc_cnt_q <= sat_inc(exc_cnt_q);
      if (mul_overflow)  ovf_cnt_q <= sat_inc(ovf_cnt_q);
    end
  end

  assign mul_a         = op_a_q;
  assign mul_b         = op_b_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_exception = exc_q;
  assign rsp_overflow  = ovf_q;
  assign busy          = (state_q != IDLE);
  assign exc_count     = exc_cnt_q;
  assign ovf_count     = ovf_cnt_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Scoreboard bench for fp_mul_scheduler: directed requests push expected tagged
// responses; a monitor pops and compares on every response handshake.
module tb_fp_mul_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     mul_a, mul_b, mul_result;
  logic            mul_exception, mul_overflow;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_exception, rsp_overflow, busy, clr_stats;
  logic [CW-1:0]   exc_count, ovf_count;
  logic            force_ovf;
  logic [33:0]     mres;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   res;
    logic          exc;
    logic          ovf;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_now = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now++;

  fp_mul_scheduler #(.NUM_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .mul_exception(mul_exception), .mul_overflow(mul_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_overflow(rsp_overflow),
    .busy(busy), .clr_stats(clr_stats), .exc_count(exc_count), .ovf_count(ovf_count)
  );

  // Simple truncating FP32 multiplier standing in for the shared unit: {exc, ovf, result}.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea, eb;
    logic [47:0]       p;
    logic signed [10:0] e;
    logic [22:0]       m;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if (ea == 8'hFF || eb == 8'hFF) return {1'b1, 1'b0, s, 8'hFF, 23'h0};
    if (ea == 8'h00 || eb == 8'h00) return {2'b00, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 11'sd1;
    end else begin
      m = p[45:23];
    end
    if (e >= 11'sd255) return {1'b0, 1'b1, s, 8'hFF, 23'h0};
    if (e <= 11'sd0)   return {2'b00, s, 31'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  always_comb mres = fmul(mul_a, mul_b);
  assign mul_result    = mres[31:0];
  assign mul_exception = mres[33];
  assign mul_overflow  = mres[32] | force_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got id %0d result %h expected no response", rsp_id, rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_exception", 64'(rsp_exception), 64'(e.exc));
        chk("rsp_overflow", 64'(rsp_overflow), 64'(e.ovf));
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [31:0] res, input logic exc, input logic ovf);
    rsp_t e;
    e.id  = IW'(id);
    e.res = res;
    e.exc = exc;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input int id);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    chk("grant", 64'(req_ready), 64'(1) << id);
  endtask

  task automatic wait_rsp_done();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rsp_seen", 64'(seen), 64'(1));
    @(posedge clk);
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc, input logic ovf,
                       input bit clr_in_exec);
    @(posedge clk); #1;
    set_req(id, a, b);
    push_exp(id, res, exc, ovf);
    wait_grant(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (clr_in_exec) clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    wait_rsp_done();
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_idx[6];
    int g_cyc[6];
    int exp_ord[6];
    int n;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; clr_stats = 1'b0; force_ovf = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_flags", 64'({rsp_exception, rsp_overflow}), 64'(0));
    chk("rst_mul_ops", {mul_a, mul_b}, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_counts", 64'({exc_count, ovf_count}), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // Single request from requester 2: 2.0 * 3.0 = 6.0
    @(posedge clk); #1;
    set_req(2, 32'h40000000, 32'h40400000);
    push_exp(2, 32'h40C00000, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("single_busy_exec", 64'(busy), 64'(1));
    chk("single_mul_a", 64'(mul_a), 64'(32'h40000000));
    chk("single_mul_b", 64'(mul_b), 64'(32'h40400000));
    chk("single_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid), 64'(1));
    @(negedge clk);
    chk("single_idle", 64'(busy), 64'(0));

    // Rotation from ptr=0 with everybody valid: operands 1.0 * (i+1)
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    foreach (g_idx[k]) begin g_idx[k] = -1; g_cyc[k] = -100; end
    foreach (exp_ord[k]) push_exp(exp_ord[k], 32'h3F800000 + (32'(exp_ord[k]) == 0 ? 32'h0 :
      exp_ord[k] == 1 ? 32'h00800000 : exp_ord[k] == 2 ? 32'h00C00000 : 32'h01000000), 1'b0, 1'b0);
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h3F800000, 32'h40000000);
    set_req(2, 32'h3F800000, 32'h40400000);
    set_req(3, 32'h3F800000, 32'h40800000);
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g_idx[n] = i;
        g_cyc[n] = cyc_now;
        n++;
        if (n == 6) begin
          @(posedge clk); #1; req_valid = '0;
        end
      end
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) chk("rot_grant", 64'(g_idx[k]), 64'(exp_ord[k]));
    for (int k = 1; k < 6; k++) chk("rot_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'(3));
    wait_drain();

    // Backpressure: 2.0*2.0 held in RESP, requester 3 waiting (1.5*... 3.0*3.0 = 9.0)
    @(posedge clk); #1; rsp_ready = 1'b0;
    set_req(0, 32'h40000000, 32'h40000000);
    push_exp(0, 32'h40800000, 1'b0, 1'b0);
    wait_grant(0);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    set_req(3, 32'h40400000, 32'h40400000);
    push_exp(3, 32'h41100000, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_id", 64'(rsp_id), 64'(0));
      chk("bp_rsp_result", 64'(rsp_result), 64'(32'h40800000));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_accept", 64'(req_ready), 64'(4'b1000));
    chk("bp_idle", 64'(busy), 64'(0));
    @(posedge clk); #1; req_valid[3] = 1'b0;
    wait_drain();

    // Exception / overflow statistics with saturation and clear
    chk("stat_exc_init", 64'(exc_count), 64'(0));
    do_op(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    chk("stat_exc_one", 64'(exc_count), 64'(1));
    chk("stat_ovf_zero", 64'(ovf_count), 64'(0));
    force_ovf = 1'b1;
    do_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b0);
    force_ovf = 1'b0;
    chk("stat_ovf_one", 64'(ovf_count), 64'(1));
    chk("stat_exc_hold", 64'(exc_count), 64'(1));
    for (int k = 0; k < 14; k++) do_op(1, 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    chk("stat_exc_full", 64'(exc_count), 64'(4'hF));
    for (int k = 0; k < 2; k++) do_op(2, 32'h40000000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    chk("stat_exc_sat", 64'(exc_count), 64'(4'hF));
    do_op(0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1, 1'b0, 1'b1);
    chk("stat_clr_exc", 64'(exc_count), 64'(0));
    chk("stat_clr_ovf", 64'(ovf_count), 64'(0));

    // Reset during EXEC abandons the operation
    @(posedge clk); #1;
    set_req(1, 32'h3F800000, 32'h40000000);
    wait_grant(1);
    @(posedge clk); #1; req_valid = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_mul_ops", {mul_a, mul_b}, 64'(0));
    chk("mid_rst_rsp", 64'({rsp_id, rsp_result, rsp_exception, rsp_overflow}), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    do_op(3, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, 1'b0);

    // Requester 1 withdraws while the block sits in RESP
    @(posedge clk); #1; rsp_ready = 1'b0;
    set_req(0, 32'h40000000, 32'h3F800000);
    push_exp(0, 32'h40000000, 1'b0, 1'b0);
    wait_grant(0);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(posedge clk); #1;
    set_req(1, 32'h40800000, 32'h40800000);
    @(negedge clk);
    chk("wd_ready_in_resp", 64'(req_ready), 64'(0));
    @(posedge clk); #1; req_valid[1] = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wd_no_grant", 64'(req_ready), 64'(0));
    end
    do_op(2, 32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Round-robin scheduler that shares one combinational single-precision floating-point multiplier among `NUM_REQ` requesters. It accepts one operand pair at a time over valid/ready handshakes and drives the shared multiplier from registered operands. It captures the product and flags, then returns them on a single tagged response channel with backpressure. It also keeps saturating exception/overflow statistics for the shared unit.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: requester tag width; must equal ceil(log2(`NUM_REQ`)).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit set.
- `req_a` in 32*`NUM_REQ`: operand A of requester i at [32i+31:32i].
- `req_b` in 32*`NUM_REQ`: operand B, same packing.
- `mul_a`, `mul_b` out 32: registered operands to the shared multiplier.
- `mul_result` in 32, `mul_exception` in 1, `mul_overflow` in 1: combinational multiplier outputs.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out `ID_W`: tag of the requester that owns the response.
- `rsp_result` out 32, `rsp_exception` out 1, `rsp_overflow` out 1: captured product and flags.
- `busy` out 1: high when the state is not IDLE.
- `clr_stats` in 1: synchronous clear of both counters.
- `exc_count`, `ovf_count` out `CNT_W`: saturating counts of captured exception and overflow results.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any `req_valid` bit is set, grant the first set bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is driven combinationally for the winner only, so it depends on `req_valid`.
  - The handshake completes in that same cycle. `op_a`/`op_b` load the winner's operands, the winner's tag is latched, and the FSM moves to EXEC.
  - With no valid request, the FSM stays in IDLE.
- EXEC:
  - `mul_a`/`mul_b` present `op_a`/`op_b`.
  - At the end of the cycle the FSM captures `mul_result`/`mul_exception`/`mul_overflow` into the response registers and moves to RESP.
  - `req_ready` is all-zero.
- RESP:
  - `rsp_valid`=1. `rsp_id`, `rsp_result` and the flags are held stable until `rsp_ready`=1.
  - On the handshake: `ptr` = (`rsp_id`+1) mod `NUM_REQ`, and the FSM moves to IDLE.
  - `req_ready` is all-zero.
- `mul_a`/`mul_b` hold the last operands outside EXEC.
- Statistics:
  - On the EXEC capture edge, `exc_count` increments if `mul_exception`=1 and `ovf_count` increments if `mul_overflow`=1.
  - Both counters saturate at all-ones.
  - `clr_stats` zeroes both counters and takes priority over a same-cycle increment.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high. Dropping `req_valid` before grant is permitted; that request is simply not taken.

## Timing
- Reset (async assert) values:
  - state IDLE, `ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, flags 0.
  - `mul_a`=`mul_b`=0, `busy`=0, counters 0.
- Reset mid-operation abandons the in-flight operation; no response is produced after release.
- Latency: request accepted in cycle k → EXEC in k+1 → `rsp_valid`=1 in k+2.
- Throughput: the next accept can happen no earlier than the cycle after the response handshake, i.e. k+3 when `rsp_ready` is held at 1. The minimum is one operation per 3 cycles.
- `busy`=1 from k+1 through the response-handshake cycle.
- The `ptr` update also applies when only one requester is active, so a sole requester is re-granted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,`NUM_REQ`-1,0 and no requester waits more than `NUM_REQ`-1 operations.

## Test plan
- **Single request:** requester 2, A=0x40000000, B=0x40400000, `rsp_ready`=1, real multiplier attached → `req_ready`=0b0100 in the accept cycle; two cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_result`=0x40C00000, flags 0.
- **Rotation:** all four requesters continuously valid, `rsp_ready`=1 → grant order 0,1,2,3,0,1, with accepts exactly 3 cycles apart.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while RESP → response outputs constant, `req_ready`=0, `busy`=1. Raise `rsp_ready` → IDLE next cycle, next accept that cycle.
- **Exception statistics:** A=0x7F800000 → `rsp_exception`=1 and `exc_count` goes 0→1. Bench model forcing `mul_overflow`=1 → `ovf_count` increments. Preload the counter near all-ones → it saturates at 0xFFFF. `clr_stats` in the capture cycle → counters 0.
- **Reset mid-operation:** `rst_n` low during EXEC → all outputs at reset values in the same cycle; after release no `rsp_valid`, and a fresh request from requester 3 is granted with `ptr`=0 search.
- **Withdrawn request:** requester 1 valid for one cycle while the block is in RESP, then deasserted → requester 1 is never granted and no response carries `rsp_id`=1.
